ram8: RTL and testbench

// - Hack-platform 8-word memory: eight WIDTH-bit registers with one write port and one read port.
// - Sits directly downstream of dmux8way. dmux8way fans the load strobe out to exactly one word

---
 rtl/hack_pkg.sv | 10 +
 rtl/ram8_if.sv | 27 ++
 rtl/dmux8way.sv | 27 ++
 rtl/mux8way16.sv | 33 +++
 rtl/register_w.sv | 34 +++
 rtl/ram8.sv | 66 ++++++
 tb/tb_ram8.sv | 154 +++++++++++++++
 7 files changed

// File: rtl/hack_pkg.sv
// Shared Hack-platform definitions: word width, RAM8 address width and the word type.
package hack_pkg;

  localparam int WORD_W      = 16;
  localparam int RAM8_ADDR_W = 3;
  localparam int RAM8_DEPTH  = 8;

  typedef logic [WORD_W-1:0] word_t;

endpackage : hack_pkg

// File: rtl/ram8_if.sv
// Bus bundle for a RAM8: write data, load strobe, word address and read data.
interface ram8_if
  import hack_pkg::*;
#(
  parameter int WIDTH = WORD_W
);

  logic [WIDTH-1:0]       in;
  logic                   load;
  logic [RAM8_ADDR_W-1:0] address;
  logic [WIDTH-1:0]       out;

  modport master (
    output in,
    output load,
    output address,
    input  out
  );

  modport slave (
    input  in,
    input  load,
    input  address,
    output out
  );

endinterface : ram8_if

// File: rtl/dmux8way.sv
// 1-to-8 demultiplexer: routes 'in' to the output bit selected by 'sel', all others 0.
// An unknown select matches no case item, so no output is raised.
module dmux8way
  import hack_pkg::*;
(
  input  logic                   in,
  input  logic [RAM8_ADDR_W-1:0] sel,
  output logic [7:0]             out
);

  // Decode the select into a single enable bit carrying 'in'.
  always_comb begin
    out = 8'b0;
    case (sel)
      3'd0:    out[0] = in;
      3'd1:    out[1] = in;
      3'd2:    out[2] = in;
      3'd3:    out[3] = in;
      3'd4:    out[4] = in;
      3'd5:    out[5] = in;
      3'd6:    out[6] = in;
      3'd7:    out[7] = in;
      default: out = 8'b0;
    endcase
  end

endmodule : dmux8way

// File: rtl/mux8way16.sv
// 8:1 multiplexer of 16-bit words selected by a 3-bit address.
module mux8way16
  import hack_pkg::*;
(
  input  word_t                  a,
  input  word_t                  b,
  input  word_t                  c,
  input  word_t                  d,
  input  word_t                  e,
  input  word_t                  f,
  input  word_t                  g,
  input  word_t                  h,
  input  logic [RAM8_ADDR_W-1:0] sel,
  output word_t                  out
);

  // Pick the word addressed by 'sel'.
  always_comb begin
    out = '0;
    case (sel)
      3'd0:    out = a;
      3'd1:    out = b;
      3'd2:    out = c;
      3'd3:    out = d;
      3'd4:    out = e;
      3'd5:    out = f;
      3'd6:    out = g;
      3'd7:    out = h;
      default: out = '0;
    endcase
  end

endmodule : mux8way16

// File: rtl/register_w.sv
// WIDTH-bit storage register with load enable and asynchronous active-low clear.
module register_w #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Next value: take new data when loaded, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = in;
    end
  end

  // Storage flop; reset clears it immediately without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign out = data_q;

endmodule : register_w

// File: rtl/ram8.sv
// Hack RAM8: eight WIDTH-bit registers, one write port and a combinational read port.
// The load strobe is fanned out by a dmux8way; reads go through an 8:1 word mux and
// show the stored value only, so a same-address write appears after the clock edge.
module ram8
  import hack_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic   clk,
  input  logic   rst_n,
  ram8_if.slave  bus
);

  logic [7:0]       word_en;
  logic [WIDTH-1:0] word_q [RAM8_DEPTH];

  dmux8way u_dmux (
    .in  (bus.load),
    .sel (bus.address),
    .out (word_en)
  );

  for (genvar gi = 0; gi < RAM8_DEPTH; gi++) begin : g_word
    register_w #(
      .WIDTH (WIDTH)
    ) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (word_en[gi]),
      .in    (bus.in),
      .out   (word_q[gi])
    );
  end

  if (WIDTH == 16) begin : g_mux16
    mux8way16 u_mux (
      .a   (word_q[0]),
      .b   (word_q[1]),
      .c   (word_q[2]),
      .d   (word_q[3]),
      .e   (word_q[4]),
      .f   (word_q[5]),
      .g   (word_q[6]),
      .h   (word_q[7]),
      .sel (bus.address),
      .out (bus.out)
    );
  end else begin : g_mux_generic
    // Generic-width read mux for non-16-bit words.
    always_comb begin
      bus.out = '0;
      case (bus.address)
        3'd0:    bus.out = word_q[0];
        3'd1:    bus.out = word_q[1];
        3'd2:    bus.out = word_q[2];
        3'd3:    bus.out = word_q[3];
        3'd4:    bus.out = word_q[4];
        3'd5:    bus.out = word_q[5];
        3'd6:    bus.out = word_q[6];
        3'd7:    bus.out = word_q[7];
        default: bus.out = '0;
      endcase
    end
  end

endmodule : ram8

// File: tb/tb_ram8.sv
// Scoreboard bench for ram8: stimulus queues expected read data, a monitor pops and compares.
module tb_ram8;
  import hack_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  ram8_if #(.WIDTH(WORD_W)) bus ();

  ram8 #(.WIDTH(WORD_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int    assertCount = 0;
  int    failCount   = 0;
  word_t expQ[$];
  string nameQ[$];
  event  sampleEv;
  word_t model [8];
  logic [7:0] onehotExp;

  // Drive the write-side bus signals.
  task automatic applyStimulus(input logic ld, input logic [2:0] addr, input word_t data);
    bus.load    = ld;
    bus.address = addr;
    bus.in      = data;
  endtask

  // Queue an expected read value and let the monitor sample it.
  task automatic checkOutput(input string name, input word_t exp);
    expQ.push_back(exp);
    nameQ.push_back(name);
    ->sampleEv;
    #2;
  endtask

  // Read every address once, expecting the reference model contents.
  task automatic sweep(input string tag);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.address = 3'(i);
      checkOutput($sformatf("%s_a%0d", tag, i), model[i]);
    end
  endtask

  // Monitor: pop one expectation per sample request and compare against the read port.
  initial begin
    word_t e;
    string n;
    forever begin
      @(sampleEv);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        assertCount++;
        if (bus.out !== e) begin
          failCount++;
          $display("[TB] FAIL %s: out=%h expected %h", n, bus.out, e);
        end
      end
    end
  end

  // Write-enable routing check on every loading edge outside reset.
  always @(posedge clk) begin
    if (rst_n && bus.load) begin
      onehotExp = 8'b1 << bus.address;
      assertCount++;
      if (dut.word_en !== onehotExp) begin
        failCount++;
        $display("[TB] FAIL onehot_a%0d: word_en=%b expected %b", bus.address, dut.word_en, onehotExp);
      end
    end
  end

  initial begin
    applyStimulus(1'b0, 3'd0, 16'h0000);
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;

    // Reset asserted mid-cycle; all words must read zero.
    #2 rst_n = 1'b0;
    sweep("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill every word with a distinct pattern.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 3'(i), word_t'(16'h1111 * (i + 1)));
      model[i] = word_t'(16'h1111 * (i + 1));
    end
    @(negedge clk);
    bus.load = 1'b0;
    sweep("wr");

    // Load low must leave memory untouched.
    @(negedge clk);
    applyStimulus(1'b0, 3'd3, 16'hFFFF);
    @(negedge clk);
    checkOutput("iso_a3", 16'h4444);
    sweep("iso");

    // Read-during-write: old value before the edge, new value after.
    @(negedge clk);
    applyStimulus(1'b1, 3'd5, 16'hBEEF);
    checkOutput("rdw_before", 16'h6666);
    model[5] = 16'hBEEF;
    @(negedge clk);
    bus.load = 1'b0;
    checkOutput("rdw_after", 16'hBEEF);
    sweep("rdw");

    // Asynchronous reset pulse between edges.
    @(negedge clk);
    #1 rst_n = 1'b0;
    checkOutput("async_rst_out", 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    sweep("rst");

    // A load edge while reset is held must not write.
    @(negedge clk);
    applyStimulus(1'b1, 3'd2, 16'h1234);
    @(negedge clk);
    bus.load = 1'b0;
    checkOutput("pre_rst_a2", 16'h1234);
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(1'b1, 3'd2, 16'hABCD);
    @(negedge clk);
    checkOutput("rst_load_a2", 16'h0000);
    bus.load = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_a2", 16'h0000);

    // Let the monitor drain, bounded.
    for (int t = 0; t < 20 && expQ.size() != 0; t++) #1;
    if (expQ.size() != 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL drain: pending=%0d expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule : tb_ram8
